// File: rtl/traffic_pkg.sv
// Shared types and constants for the intersection sequencer.
package traffic_pkg;

   localparam int COUNT_W = 5;

   // Gray-style encoding: every legal transition flips exactly one bit.
   typedef enum logic [2:0] {
      OFF       = 3'b000,
      NS_GREEN  = 3'b001,
      NS_YELLOW = 3'b011,
      NS_CLEAR  = 3'b010,
      EW_GREEN  = 3'b110,
      EW_YELLOW = 3'b111,
      EW_CLEAR  = 3'b101
   } state_t;

   localparam logic [1:0] LIGHT_OFF    = 2'b00;
   localparam logic [1:0] LIGHT_RED    = 2'b01;
   localparam logic [1:0] LIGHT_YELLOW = 2'b10;
   localparam logic [1:0] LIGHT_GREEN  = 2'b11;

   localparam logic [COUNT_W-1:0] GREEN_MIN_DEFAULT        = 5'd10;
   localparam logic [COUNT_W-1:0] GREEN_MAX_DEFAULT        = 5'd25;
   localparam logic [COUNT_W-1:0] YELLOW_DURATION_DEFAULT  = 5'd3;
   localparam logic [COUNT_W-1:0] ALL_RED_DURATION_DEFAULT = 5'd2;
   localparam logic [COUNT_W-1:0] WALK_DURATION_DEFAULT    = 5'd8;

   function automatic logic is_green(input state_t s);
      return (s == NS_GREEN) || (s == EW_GREEN);
   endfunction

endpackage

// File: rtl/intersection_scheduler_tick_down_counter.sv
// Loadable 5-bit down-counter that only moves on tick; done_next flags the
// tick that will take it from 1 to 0.
module tick_down_counter
   import traffic_pkg::*;
(
   input  logic               clk,
   input  logic               reset,
   input  logic               load,
   input  logic [COUNT_W-1:0] value,
   input  logic               tick,
   output logic [COUNT_W-1:0] count,
   output logic               done_next
);

   assign done_next = (count == 5'd1) && tick;

   // Load wins over counting; the count parks at zero.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count <= '0;
      end else if (load) begin
         count <= value;
      end else if (tick && (count != 5'd0)) begin
         count <= count - 5'd1;
      end
   end

endmodule

// File: rtl/intersection_scheduler.sv
// Two-approach intersection sequencer: owns phase order, demand-actuated green
// length, pedestrian walk grants and the light/walk decode.
//
// state     | meaning
// ----------+-------------------------------------------------
// OFF       | lights dark, waiting for start
// NS_GREEN  | NS green, EW red, optional NS walk at phase start
// NS_YELLOW | NS yellow, EW red
// NS_CLEAR  | both red after NS yellow
// EW_GREEN  | EW green, NS red, optional EW walk at phase start
// EW_YELLOW | EW yellow, NS red
// EW_CLEAR  | both red after EW yellow, then back to NS_GREEN
module intersection_scheduler
   import traffic_pkg::*;
#(
   parameter logic [COUNT_W-1:0] GREEN_MIN        = GREEN_MIN_DEFAULT,
   parameter logic [COUNT_W-1:0] GREEN_MAX        = GREEN_MAX_DEFAULT,
   parameter logic [COUNT_W-1:0] YELLOW_DURATION  = YELLOW_DURATION_DEFAULT,
   parameter logic [COUNT_W-1:0] ALL_RED_DURATION = ALL_RED_DURATION_DEFAULT,
   parameter logic [COUNT_W-1:0] WALK_DURATION    = WALK_DURATION_DEFAULT
)
(
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic       tick,
   input  logic       car_ns,
   input  logic       car_ew,
   input  logic       ped_ns,
   input  logic       ped_ew,
   output logic [1:0] L_ns,
   output logic [1:0] L_ew,
   output logic       walk_ns,
   output logic       walk_ew,
   output logic [2:0] phase
);

   // The walk must be over before the earliest demand-driven green exit.
   if (WALK_DURATION > GREEN_MIN) begin : g_walk_check
      $error("WALK_DURATION must not exceed GREEN_MIN");
   end

   state_t state;
   state_t next_state;

   logic               lat_ns;
   logic               lat_ew;
   logic [COUNT_W-1:0] elapsed;
   logic [COUNT_W:0]   e_next;

   logic               ph_load;
   logic [COUNT_W-1:0] ph_value;
   logic [COUNT_W-1:0] ph_count;
   logic               ph_done;

   logic               wk_load;
   logic [COUNT_W-1:0] wk_value;
   logic [COUNT_W-1:0] wk_count;
   logic               wk_done;

   logic enter_ns;
   logic enter_ew;
   logic opp_demand;
   logic walk_finished;
   logic green_exit;
   logic ph_expired;

   // Six bits so the elapsed+1 compare never wraps at 31.
   assign e_next = {1'b0, elapsed} + 6'd1;

   assign opp_demand    = (state == NS_GREEN) ? (car_ew | lat_ew) : (car_ns | lat_ns);
   assign walk_finished = (wk_count == 5'd0) || wk_done;
   assign green_exit    = ((e_next >= {1'b0, GREEN_MIN}) && opp_demand && walk_finished)
                          || (e_next >= {1'b0, GREEN_MAX});

   // A zero count in yellow/clear can only come from a zero duration; leave
   // immediately rather than stall.
   assign ph_expired = ph_done || (ph_count == 5'd0);

   assign enter_ns = (next_state == NS_GREEN) && (state != NS_GREEN);
   assign enter_ew = (next_state == EW_GREEN) && (state != EW_GREEN);

   assign ph_load  = (next_state != state) &&
                     ((next_state == NS_YELLOW) || (next_state == EW_YELLOW) ||
                      (next_state == NS_CLEAR)  || (next_state == EW_CLEAR));
   assign ph_value = ((next_state == NS_YELLOW) || (next_state == EW_YELLOW))
                     ? YELLOW_DURATION : ALL_RED_DURATION;

   // Every green entry reloads the walk counter, with zero when nobody asked.
   assign wk_load  = enter_ns | enter_ew;
   assign wk_value = ((enter_ns && (lat_ns | ped_ns)) || (enter_ew && (lat_ew | ped_ew)))
                     ? WALK_DURATION : 5'd0;

   tick_down_counter u_phase_cnt (
      .clk       (clk),
      .reset     (reset),
      .load      (ph_load),
      .value     (ph_value),
      .tick      (tick),
      .count     (ph_count),
      .done_next (ph_done)
   );

   tick_down_counter u_walk_cnt (
      .clk       (clk),
      .reset     (reset),
      .load      (wk_load),
      .value     (wk_value),
      .tick      (tick),
      .count     (wk_count),
      .done_next (wk_done)
   );

   // State register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= OFF;
      end else begin
         state <= next_state;
      end
   end

   // Next-state: green ends on demand or max, yellow/clear on the phase counter.
   always_comb begin
      next_state = state;
      case (state)
         OFF:       if (start)               next_state = NS_GREEN;
         NS_GREEN:  if (tick && green_exit)  next_state = NS_YELLOW;
         NS_YELLOW: if (tick && ph_expired)  next_state = NS_CLEAR;
         NS_CLEAR:  if (tick && ph_expired)  next_state = EW_GREEN;
         EW_GREEN:  if (tick && green_exit)  next_state = EW_YELLOW;
         EW_YELLOW: if (tick && ph_expired)  next_state = EW_CLEAR;
         EW_CLEAR:  if (tick && ph_expired)  next_state = NS_GREEN;
         default:                            next_state = OFF;
      endcase
   end

   // Green elapsed ticks, restarted on every state change and saturating.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         elapsed <= '0;
      end else if (next_state != state) begin
         elapsed <= '0;
      end else if (tick && is_green(state) && (elapsed != 5'd31)) begin
         elapsed <= elapsed + 5'd1;
      end
   end

   // Ped latches: a request in the entry cycle is absorbed by that grant.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         lat_ns <= 1'b0;
         lat_ew <= 1'b0;
      end else begin
         if (enter_ns)    lat_ns <= 1'b0;
         else if (ped_ns) lat_ns <= 1'b1;
         if (enter_ew)    lat_ew <= 1'b0;
         else if (ped_ew) lat_ew <= 1'b1;
      end
   end

   // Moore light decode of the registered state.
   always_comb begin
      L_ns = LIGHT_OFF;
      L_ew = LIGHT_OFF;
      case (state)
         NS_GREEN:  begin L_ns = LIGHT_GREEN;  L_ew = LIGHT_RED;    end
         NS_YELLOW: begin L_ns = LIGHT_YELLOW; L_ew = LIGHT_RED;    end
         NS_CLEAR:  begin L_ns = LIGHT_RED;    L_ew = LIGHT_RED;    end
         EW_GREEN:  begin L_ns = LIGHT_RED;    L_ew = LIGHT_GREEN;  end
         EW_YELLOW: begin L_ns = LIGHT_RED;    L_ew = LIGHT_YELLOW; end
         EW_CLEAR:  begin L_ns = LIGHT_RED;    L_ew = LIGHT_RED;    end
         default:   begin L_ns = LIGHT_OFF;    L_ew = LIGHT_OFF;    end
      endcase
   end

   assign walk_ns = (state == NS_GREEN) && (wk_count != 5'd0);
   assign walk_ew = (state == EW_GREEN) && (wk_count != 5'd0);
   assign phase   = state;

endmodule

// File: tb/tb_intersection_scheduler.sv
// Bench for intersection_scheduler: vector table, hand-written corner
// sequences and a randomized run against a behavioural reference model.
module tb_intersection_scheduler;

   localparam int GMIN = 10;
   localparam int GMAX = 25;
   localparam int YEL  = 3;
   localparam int CLR  = 2;
   localparam int WALK = 8;

   // {L_ns, L_ew, walk_ns, walk_ew}
   localparam logic [5:0] P_OFF   = 6'b00_00_0_0;
   localparam logic [5:0] P_NSG   = 6'b11_01_0_0;
   localparam logic [5:0] P_NSG_W = 6'b11_01_1_0;
   localparam logic [5:0] P_NSY   = 6'b10_01_0_0;
   localparam logic [5:0] P_CLR   = 6'b01_01_0_0;
   localparam logic [5:0] P_EWG   = 6'b01_11_0_0;
   localparam logic [5:0] P_EWG_W = 6'b01_11_0_1;
   localparam logic [5:0] P_EWY   = 6'b01_10_0_0;

   logic       clk = 1'b0;
   logic       reset, start, tick, car_ns, car_ew, ped_ns, ped_ew;
   logic [1:0] L_ns, L_ew;
   logic       walk_ns, walk_ew;
   logic [2:0] phase;
   logic [5:0] outs;

   int n_cmp  = 0;
   int n_fail = 0;

   intersection_scheduler dut (
      .clk     (clk),
      .reset   (reset),
      .start   (start),
      .tick    (tick),
      .car_ns  (car_ns),
      .car_ew  (car_ew),
      .ped_ns  (ped_ns),
      .ped_ew  (ped_ew),
      .L_ns    (L_ns),
      .L_ew    (L_ew),
      .walk_ns (walk_ns),
      .walk_ew (walk_ew),
      .phase   (phase)
   );

   assign outs = {L_ns, L_ew, walk_ns, walk_ew};

   always #5 clk = ~clk;

   // Safety: never two non-red approaches, never a walk outside its green.
   always @(negedge clk) begin
      n_cmp++;
      if ((L_ns[1] && L_ew[1]) || (walk_ns && L_ns != 2'b11) || (walk_ew && L_ew != 2'b11)) begin
         n_fail++;
         $display("FAIL safety: L_ns=%b L_ew=%b walk_ns=%b walk_ew=%b, required no overlap",
                  L_ns, L_ew, walk_ns, walk_ew);
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [5:0] exp);
      n_cmp++;
      if (outs !== exp) begin
         n_fail++;
         $display("FAIL %s: got L_ns=%b L_ew=%b walk=%b%b, required L_ns=%b L_ew=%b walk=%b%b",
                  name, outs[5:4], outs[3:2], outs[1], outs[0], exp[5:4], exp[3:2], exp[1], exp[0]);
      end
   endtask

   task automatic check_n(input string name, input int got, input int exp);
      n_cmp++;
      if (got != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d cycles, required %0d", name, got, exp);
      end
   endtask

   // Counts consecutive cycles (including the current one) showing pat.
   task automatic measure(input logic [5:0] pat, output int n);
      n = 0;
      while (outs === pat && n < 100) begin
         n++;
         step();
      end
   endtask

   task automatic wait_for(input logic [5:0] pat);
      int k = 0;
      while (outs !== pat && k < 100) begin
         step();
         k++;
      end
   endtask

   task automatic idle_inputs();
      reset = 0; start = 0; tick = 1;
      car_ns = 0; car_ew = 0; ped_ns = 0; ped_ew = 0;
   endtask

   task automatic do_reset();
      idle_inputs();
      reset = 1;
      step();
      reset = 0;
   endtask

   // ---------------- reference model ----------------
   int m_on, m_app, m_stage, m_cnt, m_walk;  // stage 0 green, 1 yellow, 2 clear
   bit m_lat [2];

   task automatic model_step(input bit rst, input bit st, input bit tk,
                             input bit [1:0] car, input bit [1:0] ped);
      int  enter;
      int  nxt;
      int  opp;
      bit  dem, wdone, grant;
      enter = -1;
      grant = 0;
      if (rst) begin
         m_on = 0; m_app = 0; m_stage = 0; m_cnt = 0; m_walk = 0;
         m_lat[0] = 0; m_lat[1] = 0;
         return;
      end
      if (m_on == 0) begin
         if (st) enter = 0;
      end else if (tk) begin
         nxt = m_cnt + 1;
         if (m_stage == 0) begin
            opp   = 1 - m_app;
            dem   = car[opp] | m_lat[opp];
            wdone = (m_walk <= 1);
            if (m_walk > 0) m_walk--;
            if ((nxt >= GMIN && dem && wdone) || nxt >= GMAX) begin
               m_stage = 1; m_cnt = 0;
            end else m_cnt = nxt;
         end else if (m_stage == 1) begin
            if (nxt == YEL) begin m_stage = 2; m_cnt = 0; end
            else m_cnt = nxt;
         end else begin
            if (nxt == CLR) enter = 1 - m_app;
            else m_cnt = nxt;
         end
      end
      for (int a = 0; a < 2; a++) begin
         if (enter == a) begin
            grant    = m_lat[a] | ped[a];
            m_lat[a] = 0;
         end else if (ped[a]) begin
            m_lat[a] = 1;
         end
      end
      if (enter >= 0) begin
         m_on = 1; m_app = enter; m_stage = 0; m_cnt = 0;
         m_walk = grant ? WALK : 0;
      end
   endtask

   function automatic logic [5:0] model_out();
      logic [1:0] l [2];
      logic       w [2];
      if (m_on == 0) return P_OFF;
      for (int a = 0; a < 2; a++) begin
         if (a == m_app) l[a] = (m_stage == 0) ? 2'b11 : (m_stage == 1) ? 2'b10 : 2'b01;
         else            l[a] = 2'b01;
         w[a] = (a == m_app) && (m_stage == 0) && (m_walk > 0);
      end
      return {l[0], l[1], w[0], w[1]};
   endfunction

   // ---------------- vector table ----------------
   typedef struct {
      logic       rst, st, tk, cns, cew, pns, pew;
      int         n;
      logic [5:0] exp;
   } vec_t;

   vec_t vt[$];

   task automatic addv(input logic r, input logic s, input logic t, input logic cn,
                       input logic ce, input logic pn, input logic pe,
                       input int n, input logic [5:0] e);
      vec_t v;
      v.rst = r; v.st = s; v.tk = t; v.cns = cn; v.cew = ce; v.pns = pn; v.pew = pe;
      v.n = n; v.exp = e;
      vt.push_back(v);
   endtask

   initial begin
      int n, g;
      logic r, s, t;
      idle_inputs();
      reset = 1;

      // No demand: full-length greens; start ignored mid-run; tick=0 freezes.
      addv(1,0,1,0,0,0,0,  2, P_OFF);
      addv(0,0,1,0,0,0,0,  3, P_OFF);
      addv(0,1,1,0,0,0,0,  1, P_NSG);
      addv(0,0,1,0,0,0,0, 24, P_NSG);
      addv(0,0,1,0,0,0,0,  3, P_NSY);
      addv(0,0,1,0,0,0,0,  2, P_CLR);
      addv(0,0,1,0,0,0,0, 25, P_EWG);
      addv(0,0,1,0,0,0,0,  3, P_EWY);
      addv(0,0,1,0,0,0,0,  2, P_CLR);
      addv(0,1,1,0,0,0,0,  3, P_NSG);
      addv(0,0,0,0,0,0,0,  4, P_NSG);
      // car_ew held from start: NS green ends at GREEN_MIN.
      addv(1,0,1,0,0,0,0,  1, P_OFF);
      addv(0,1,1,0,1,0,0,  1, P_NSG);
      addv(0,0,1,0,1,0,0,  9, P_NSG);
      addv(0,0,1,0,1,0,0,  3, P_NSY);
      addv(0,0,1,0,1,0,0,  2, P_CLR);
      addv(0,0,1,0,1,0,0,  5, P_EWG);
      addv(0,0,0,0,1,0,0,  3, P_EWG);

      foreach (vt[i]) begin
         for (int k = 0; k < vt[i].n; k++) begin
            reset = vt[i].rst; start = vt[i].st; tick = vt[i].tk;
            car_ns = vt[i].cns; car_ew = vt[i].cew; ped_ns = vt[i].pns; ped_ew = vt[i].pew;
            step();
            check($sformatf("vec%0d.%0d", i, k), vt[i].exp);
         end
      end

      // Pedestrian request mid NS green, then a repeat request during EW green.
      do_reset();
      start = 1; step(); start = 0;
      g = 1;
      for (int k = 0; k < 3; k++) begin step(); g++; end
      ped_ew = 1; step(); ped_ew = 0; g++;
      measure(P_NSG, n);   check_n("ped_ns_green_len", g - 1 + n, GMIN);
      measure(P_NSY, n);   check_n("ped_ns_yellow_len", n, YEL);
      measure(P_CLR, n);   check_n("ped_clear_len", n, CLR);
      measure(P_EWG_W, n); check_n("ped_walk_ew_len", n, WALK);
      check("ped_walk_off", P_EWG);
      ped_ew = 1; step(); ped_ew = 0;
      measure(P_EWG, n);   check_n("ped_ew_green_len", WALK + 1 + n, GMAX);
      measure(P_EWY, n);   check_n("ped_ew_yellow_len", n, YEL);
      measure(P_CLR, n);   check_n("ped_clear2_len", n, CLR);
      measure(P_NSG, n);   check_n("ped_ns_green2_len", n, GMIN);
      measure(P_NSY, n);   check_n("ped_ns_yellow2_len", n, YEL);
      measure(P_CLR, n);   check_n("ped_clear3_len", n, CLR);
      measure(P_EWG_W, n); check_n("ped_walk_ew2_len", n, WALK);

      // tick held low inside NS yellow.
      do_reset();
      car_ew = 1;
      start = 1; step(); start = 0;
      wait_for(P_NSY);
      check("frz_enter", P_NSY);
      step(); check("frz_y1", P_NSY);
      tick = 0;
      for (int k = 0; k < 7; k++) begin
         step(); check($sformatf("frz_hold%0d", k), P_NSY);
      end
      tick = 1;
      step(); check("frz_y2", P_NSY);
      step(); check("frz_exit", P_CLR);

      // Asynchronous reset during EW yellow.
      do_reset();
      car_ew = 1;
      start = 1; step(); start = 0;
      wait_for(P_EWG);
      car_ew = 0; car_ns = 1;
      wait_for(P_EWY);
      check("rst_in_ewy", P_EWY);
      reset = 1;
      #1;
      check("rst_async", P_OFF);
      step(); step();
      check("rst_held", P_OFF);
      reset = 0;
      for (int k = 0; k < 5; k++) begin
         step(); check($sformatf("rst_stay_off%0d", k), P_OFF);
      end
      start = 1; step(); start = 0;
      check("rst_restart", P_NSG);

      // Both cars waiting: alternate at GREEN_MIN.
      do_reset();
      car_ns = 1; car_ew = 1;
      start = 1; step(); start = 0;
      measure(P_NSG, n); check_n("both_ns_green", n, GMIN);
      measure(P_NSY, n); check_n("both_ns_yellow", n, YEL);
      measure(P_CLR, n); check_n("both_clear", n, CLR);
      measure(P_EWG, n); check_n("both_ew_green", n, GMIN);
      measure(P_EWY, n); check_n("both_ew_yellow", n, YEL);
      measure(P_CLR, n); check_n("both_clear2", n, CLR);
      measure(P_NSG, n); check_n("both_ns_green2", n, GMIN);

      // Randomized run against the reference model.
      idle_inputs();
      for (int i = 0; i < 4000; i++) begin
         r = (i == 0) || ($urandom_range(0, 599) == 0);
         s = ($urandom_range(0, 7) == 0);
         t = ($urandom_range(0, 3) != 0);
         reset = r; start = s; tick = t;
         if ($urandom_range(0, 15) == 0) car_ns = ~car_ns;
         if ($urandom_range(0, 15) == 0) car_ew = ~car_ew;
         ped_ns = ($urandom_range(0, 29) == 0);
         ped_ew = ($urandom_range(0, 29) == 0);
         @(posedge clk);
         model_step(r, s, t, {car_ew, car_ns}, {ped_ew, ped_ns});
         #1;
         check($sformatf("rand%0d", i), model_out());
      end
      idle_inputs();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
